// File: rtl/level_token_controller.sv
// level_token_controller
//   Drives one level of a tile-based game. On reset it rewrites every token
//   tile with TKN (RESTORE), then in PLAY it turns touched tokens into SKY
//   tiles, counts collected tokens down and runs a seconds countdown. It
//   settles in WIN or LOSE until the next reset.
//
// Ports
//   vga_clock        single clock
//   reset            synchronous active-high reset
//   token_col/row    packed background column (5b) / row (4b) per token
//   touch            per-token contact level from the coin detectors
//   hazard_hit       enemy contact level
//   tile_we/row/col/value  registered single write port into the background
//   collected        sticky per-token collected flags
//   tokens_remaining tokens still to collect
//   seconds          time left
//   state            0 RESTORE, 1 PLAY, 2 WIN, 3 LOSE
//   win/lose         decoded from the state register

module level_token_controller #(
  parameter int unsigned NUM_TOKENS        = 3,
  parameter int unsigned TIME_LIMIT_S      = 60,
  parameter int unsigned CLOCKS_PER_SECOND = 25_000_000,
  parameter logic [7:0]  SKY               = 8'd1,
  parameter logic [7:0]  TKN               = 8'd4
) (
  input  logic                    vga_clock,
  input  logic                    reset,
  input  logic [NUM_TOKENS*5-1:0] token_col,
  input  logic [NUM_TOKENS*4-1:0] token_row,
  input  logic [NUM_TOKENS-1:0]   touch,
  input  logic                    hazard_hit,
  output logic                    tile_we,
  output logic [3:0]              tile_row,
  output logic [4:0]              tile_col,
  output logic [7:0]              tile_value,
  output logic [NUM_TOKENS-1:0]   collected,
  output logic [4:0]              tokens_remaining,
  output logic [7:0]              seconds,
  output logic [1:0]              state,
  output logic                    win,
  output logic                    lose
);

  localparam logic [1:0] StRestore = 2'd0;
  localparam logic [1:0] StPlay    = 2'd1;
  localparam logic [1:0] StWin     = 2'd2;
  localparam logic [1:0] StLose    = 2'd3;

  localparam int unsigned PW = $clog2(CLOCKS_PER_SECOND);
  localparam logic [PW-1:0] PrescLast = PW'(CLOCKS_PER_SECOND - 1);

  logic [1:0]            state_q, state_d;
  logic [4:0]            ridx_q, ridx_d;
  logic [NUM_TOKENS-1:0] pending_q, pending_d;
  logic [NUM_TOKENS-1:0] collected_q, collected_d;
  logic [4:0]            remaining_q, remaining_d;
  logic [7:0]            seconds_q, seconds_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  tile_we_q, tile_we_d;
  logic [3:0]            tile_row_q, tile_row_d;
  logic [4:0]            tile_col_q, tile_col_d;
  logic [7:0]            tile_value_q, tile_value_d;

  // Lowest-index pending token, as one-hot mask and as index.
  logic                  svc_valid;
  logic [3:0]            svc_idx;
  logic [NUM_TOKENS-1:0] svc_mask;

  always_comb begin
    svc_valid = 1'b0;
    svc_idx   = '0;
    svc_mask  = '0;
    for (int i = 0; i < int'(NUM_TOKENS); i++) begin
      if (pending_q[i] && !svc_valid) begin
        svc_valid   = 1'b1;
        svc_idx     = 4'(i);
        svc_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ridx_d       = ridx_q;
    pending_d    = pending_q;
    collected_d  = collected_q;
    remaining_d  = remaining_q;
    seconds_d    = seconds_q;
    presc_d      = presc_q;
    tile_we_d    = 1'b0;
    tile_row_d   = tile_row_q;
    tile_col_d   = tile_col_q;
    tile_value_d = tile_value_q;

    case (state_q)
      StRestore: begin
        pending_d = '0;
        if (ridx_q < 5'(NUM_TOKENS)) begin
          tile_we_d    = 1'b1;
          tile_row_d   = token_row[4*ridx_q[3:0] +: 4];
          tile_col_d   = token_col[5*ridx_q[3:0] +: 5];
          tile_value_d = TKN;
          ridx_d       = ridx_q + 5'd1;
        end else begin
          // One idle cycle after the last write, then play starts.
          state_d = StPlay;
        end
      end

      StPlay: begin
        // The token being serviced is masked so a held touch cannot re-arm it
        // before its collected flag is visible.
        pending_d = (pending_q | (touch & ~collected_q)) & ~svc_mask;
        if (svc_valid) begin
          tile_we_d    = 1'b1;
          tile_row_d   = token_row[4*svc_idx +: 4];
          tile_col_d   = token_col[5*svc_idx +: 5];
          tile_value_d = SKY;
          collected_d  = collected_q | svc_mask;
          remaining_d  = remaining_q - 5'd1;
        end

        if (presc_q == PrescLast) begin
          presc_d = '0;
          if (seconds_q != 8'd0) seconds_d = seconds_q - 8'd1;
        end else begin
          presc_d = presc_q + PW'(1);
        end

        // Losing wins ties with winning.
        if (hazard_hit || (seconds_q == 8'd0)) begin
          state_d = StLose;
        end else if (remaining_q == 5'd0) begin
          state_d = StWin;
        end
      end

      default: begin
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state_q      <= StRestore;
      ridx_q       <= '0;
      pending_q    <= '0;
      collected_q  <= '0;
      remaining_q  <= 5'(NUM_TOKENS);
      seconds_q    <= 8'(TIME_LIMIT_S);
      presc_q      <= '0;
      tile_we_q    <= 1'b0;
      tile_row_q   <= '0;
      tile_col_q   <= '0;
      tile_value_q <= '0;
    end else begin
      state_q      <= state_d;
      ridx_q       <= ridx_d;
      pending_q    <= pending_d;
      collected_q  <= collected_d;
      remaining_q  <= remaining_d;
      seconds_q    <= seconds_d;
      presc_q      <= presc_d;
      tile_we_q    <= tile_we_d;
      tile_row_q   <= tile_row_d;
      tile_col_q   <= tile_col_d;
      tile_value_q <= tile_value_d;
    end
  end

  assign tile_we          = tile_we_q;
  assign tile_row         = tile_row_q;
  assign tile_col         = tile_col_q;
  assign tile_value       = tile_value_q;
  assign collected        = collected_q;
  assign tokens_remaining = remaining_q;
  assign seconds          = seconds_q;
  assign state            = state_q;
  assign win              = (state_q == StWin);
  assign lose             = (state_q == StLose);

endmodule
